mem_strb_pipe: RTL

Parametrised single-port memory behind the AXI4 slave's memory-side interface. It is the successor to the plain en/we word memory. It adds:
- per-byte write strobes
- configurable read latency with a read-valid pulse
- an out-of-range error flag
- a hardware clear-on-reset sweep that gates requests through a ready flag

The AXI4 slave front end drives it directly, and benches drive it through the shared arbiter interface.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_rd_pipe.sv | 52 +++++
 rtl/mem_strb_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types, limits and parameter sanity helpers for the strobed memory.
package mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_READ_LATENCY = 4;

    // Number of byte lanes in a word of the given width.
    function automatic int STRB_W(input int data_width);
        return data_width / 8;
    endfunction

    function automatic bit data_width_ok(input int data_width);
        return (data_width > 0) && (data_width % 8 == 0);
    endfunction

    function automatic bit read_latency_ok(input int read_latency);
        return (read_latency >= 1) && (read_latency <= MAX_READ_LATENCY);
    endfunction

    function automatic bit depth_ok(input int depth, input int addr_width);
        return (depth >= 1) && (longint'(depth) <= (64'd1 << addr_width));
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: LATENCY register stages carrying {valid, err, data}.
// Data stages only load behind a valid beat, so the last stage holds the
// most recent read result between pulses.
module mem_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    err_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    // Shift the read beat one stage per cycle; a reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage read the value
            // its neighbour held before this edge, giving a true shift chain.
            valid_q[0] <= in_valid;
            err_q[0]   <= in_valid & in_err;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mem_strb_pipe.sv
// Single-port word memory with byte strobes, a configurable read-return
// latency, out-of-range error pulses and an optional zeroing sweep after reset.
module mem_strb_pipe
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int MEMORY_DEPTH   = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          mem_en,
    input  logic                          mem_we,
    input  logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [STRB_W(DATA_WIDTH)-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          mem_rvalid,
    output logic                          mem_err,
    output logic                          mem_ready
);

    localparam int SW = STRB_W(DATA_WIDTH);
    localparam int IW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int CW = $clog2(MEMORY_DEPTH + 1);

    localparam logic [CW-1:0]       DEPTH_CNT  = CW'(MEMORY_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_ADDR = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);

    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
        $error("mem_strb_pipe: DATA_WIDTH must be a positive multiple of 8");
    end
    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
        $error("mem_strb_pipe: READ_LATENCY must be within 1..MAX_READ_LATENCY");
    end
    if (!depth_ok(MEMORY_DEPTH, ADDR_WIDTH)) begin : g_bad_depth
        $error("mem_strb_pipe: MEMORY_DEPTH must not exceed 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sweep_we;
    logic                  accept;
    logic                  in_range;
    logic                  wr_en;
    logic                  wr_err_q;
    logic                  rd_valid;
    logic                  rd_err;
    logic [IW-1:0]         word_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign mem_ready = (state_q == RUN);
    assign accept    = mem_en && mem_ready;
    assign in_range  = ({1'b0, mem_addr} < DEPTH_ADDR);
    assign word_idx  = mem_addr[IW-1:0];
    assign wr_en     = accept && mem_we && in_range;
    assign rd_valid  = accept && !mem_we;
    assign rd_err    = !in_range;
    assign rd_word   = in_range ? mem[word_idx] : '0;

    // State register and sweep counter; reset restarts the sweep from word 0.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one word per cycle, then open the request port.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch can be inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        case (state_q)
            INIT: begin
                if (CLEAR_ON_RESET == 0 || cnt_q == DEPTH_CNT) begin
                    state_d = RUN;
                end else begin
                    sweep_we = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Array write port: sweep zeroing during INIT, strobe-merged writes in RUN.
    always_ff @(posedge ACLK) begin
        // NOTE: the array deliberately has no reset; clearing it is the job
        // of the sweep, which keeps the storage mappable onto RAM macros.
        if (sweep_we) begin
            mem[cnt_q[IW-1:0]] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < SW; b++) begin
                if (mem_wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Out-of-range writes report one cycle after acceptance.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= accept && mem_we && !in_range;
        end
    end

    logic pipe_err;

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .in_valid  (rd_valid),
        .in_err    (rd_err),
        .in_data   (rd_word),
        .out_valid (mem_rvalid),
        .out_err   (pipe_err),
        .out_data  (mem_rdata)
    );

    assign mem_err = wr_err_q | pipe_err;

endmodule
